instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 40 ++++
 rtl/instr_encoder_sync_fifo2.sv | 52 +++++
 rtl/instr_encoder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants: opcodes, instruction class codes and
// funct3 legality helpers used by the encoder and control-unit tests.
package instr_encoder_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] CLS_LOAD   = 3'd0;
   localparam logic [2:0] CLS_STORE  = 3'd1;
   localparam logic [2:0] CLS_R      = 3'd2;
   localparam logic [2:0] CLS_IALU   = 3'd3;
   localparam logic [2:0] CLS_BRANCH = 3'd4;

   localparam logic [2:0] F3_LS_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [2:0] F3_BNE     = 3'b001;
   localparam logic [2:0] F3_BLT     = 3'b100;
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

   function automatic logic branch_f3_ok(input logic [2:0] f3);
      return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT);
   endfunction

   // funct3 values that have an alternate (funct7[5]=1) R-type form
   function automatic logic rtype_alt_ok(input logic [2:0] f3);
      return (f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA);
   endfunction

   function automatic logic is_shift_f3(input logic [2:0] f3);
      return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
   endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo2.sv
// Two-entry synchronous FIFO; push while full is accepted when a pop
// frees a slot in the same cycle.
module sync_fifo2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [1:0]       occ
);

   logic [1:0][WIDTH-1:0] mem_q, mem_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [1:0]            occ_q, occ_d;
   logic                  do_push, do_pop;

   assign empty   = (occ_q == 2'd0);
   assign full    = (occ_q == 2'd2);
   assign occ     = occ_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      if (do_push) mem_d[wr_ptr_q] = wdata;
      wr_ptr_d = wr_ptr_q ^ do_push;
      rd_ptr_d = rd_ptr_q ^ do_pop;
      occ_d    = occ_q + {1'b0, do_push} - {1'b0, do_pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Encodes a stream of RV32I instruction descriptions into machine words and
// writes them to sequential memory addresses through a 2-entry FIFO.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        finish,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_class,
   input  logic [2:0]  in_funct3,
   input  logic        in_funct7b5,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [12:0] in_imm,
   output logic        mem_we,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [6:0]  count,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [7:0] DEPTH_L = 8'(DEPTH);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [6:0]  count_q, count_d;
   logic        err_q, err_d;
   logic        done_q, done_d;

   logic [31:0] enc_word;
   logic        enc_illegal;
   logic        fifo_full, fifo_empty;
   logic [1:0]  fifo_occ;
   logic [7:0]  pending;
   logic        accept, push, pop;

   // Words already written plus words queued; bounds the program length.
   assign pending  = {1'b0, count_q} + {6'b0, fifo_occ};
   assign in_ready = (state_q == ST_RUN) && !fifo_full && (pending < DEPTH_L);
   assign accept   = in_valid && in_ready;
   assign push     = accept && !enc_illegal;
   assign mem_we   = !fifo_empty;
   assign pop      = mem_we && mem_ready;

   assign mem_addr = addr_q;
   assign count    = count_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign err      = err_q;

   always_comb begin
      enc_word    = 32'h0;
      enc_illegal = 1'b0;
      case (in_class)
         CLS_LOAD: begin
            enc_word    = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            enc_illegal = (in_funct3 != F3_LS_WORD);
         end
         CLS_STORE: begin
            enc_word    = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            enc_illegal = (in_funct3 != F3_LS_WORD);
         end
         CLS_R: begin
            enc_word    = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_OP};
            enc_illegal = in_funct7b5 && !rtype_alt_ok(in_funct3);
         end
         CLS_IALU: begin
            // Shifts carry funct7 in the upper bits and shamt in imm[4:0]
            if (is_shift_f3(in_funct3))
               enc_word = {1'b0, in_funct7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_OP_IMM};
            else
               enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_OP_IMM};
         end
         CLS_BRANCH: begin
            enc_word    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], OP_BRANCH};
            enc_illegal = !branch_f3_ok(in_funct3) || in_imm[0];
         end
         default: enc_illegal = 1'b1;
      endcase
   end

   sync_fifo2 #(.WIDTH(32)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (enc_word),
      .pop   (pop),
      .rdata (mem_wdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .occ   (fifo_occ)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      err_d   = err_q;
      done_d  = 1'b0;
      if (pop) begin
         addr_d  = addr_q + 32'd4;
         count_d = count_q + 7'd1;
      end
      if (accept && enc_illegal) err_d = 1'b1;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_RUN;
            addr_d  = BASE_ADDR;
            count_d = 7'd0;
            err_d   = 1'b0;
         end
         ST_RUN: if (finish || (pending == DEPTH_L)) state_d = ST_DRAIN;
         ST_DRAIN: if (fifo_empty) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= BASE_ADDR;
         count_q <= 7'd0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

endmodule
